core_mem_responder: RTL

- Memory-side responder for the rv32e core bus. It is the slave end of the core's addr/write-strobe/data/stall interface.
- Accepts one word access per non-stalled cycle from a byte-lane-writable word array.
- Stretches each access by a configurable number of wait states by asserting stall toward the core.
- Flags out-of-range accesses; this is the on-chip RAM model behind each tile's CPU.

---
 rtl/core_mem_pkg.sv | 34 +++
 rtl/core_mem_ram.sv | 56 +++++
 rtl/core_mem_responder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/core_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_pkg
//  Description : Shared types and helpers for the core-bus memory responder.
//                Holds the responder FSM state type, the word size in bytes,
//                the wait-state counter width and the address range check.
//  Revision    : 1.0  initial release
// ============================================================================
package core_mem_pkg;

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_WAIT   = 1'b1
    } state_t;

    localparam int WORD_BYTES   = 4;
    localparam int c_WAIT_CNT_W = 4;

    // Unsigned 32-bit offset compare: addresses below the base wrap to a
    // huge offset and are therefore reported as out of range as well.
    function automatic logic in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned words
    );
        logic [31:0] off;
        logic [31:0] lim;
        off = addr - base;
        lim = words * WORD_BYTES;
        return (off < lim);
    endfunction

endpackage
`default_nettype wire

// File: rtl/core_mem_ram.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_ram
//  Description : Single-port MEM_WORDS x 32 word array with per-byte write
//                enables and a registered read port. The read register can
//                be loaded with zero instead of array data.
//  Ports       : clk        - clock
//                rst        - synchronous active-high reset (read reg only)
//                i_idx      - word index
//                i_we       - per-byte write enables
//                i_wdata    - write data
//                i_rd_en    - load read register from array[i_idx]
//                i_rd_zero  - load read register with zero
//                o_rdata    - registered read data
//  Revision    : 1.0  initial release
// ============================================================================
module core_mem_ram
    import core_mem_pkg::*;
#(
    parameter int MEM_WORDS = 4096,
    parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       i_idx,
    input  logic [WORD_BYTES-1:0]   i_we,
    input  logic [31:0]             i_wdata,
    input  logic                    i_rd_en,
    input  logic                    i_rd_zero,
    output logic [31:0]             o_rdata
);

    // Array contents are deliberately left without reset.
    logic [31:0] r_mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (i_we[b]) begin
                r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Non-blocking read of the array returns the pre-write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rdata <= 32'h0;
        end else if (i_rd_en) begin
            o_rdata <= r_mem[i_idx];
        end else if (i_rd_zero) begin
            o_rdata <= 32'h0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/core_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_responder
//  Description : Memory-side responder for the rv32e core bus. Every
//                non-stalled cycle is one word access; each access can be
//                stretched by WAIT_STATES stall cycles. Out-of-range accesses
//                read zero, drop writes and set a sticky error flag.
//  Ports       : clock, reset (sync, active high)
//                addr_in   - byte address, bits [1:0] ignored
//                wb_in     - byte write strobes, 0 means read
//                data_in   - write data
//                data_out  - registered read data
//                stall_out - holds the core while an access is in progress
//                err_out   - sticky out-of-range flag
//                rd_count_out / wr_count_out - saturating access counters
//                (only with CORE_MEM_RESPONDER_STATS_EN defined)
//  Options     : CORE_MEM_RESPONDER_STATS_EN enables the access counters.
//  Revision    : 1.0  initial release
// ============================================================================
module core_mem_responder
    import core_mem_pkg::*;
#(
    parameter int          MEM_WORDS    = 4096,
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
    parameter int          WAIT_STATES  = 0,
    parameter int          MEMORY_WIDTH = 32
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [31:0]             addr_in,
    input  logic [3:0]              wb_in,
    input  logic [MEMORY_WIDTH-1:0] data_in,
    output logic [MEMORY_WIDTH-1:0] data_out,
    output logic                    stall_out,
    output logic                    err_out
`ifdef CORE_MEM_RESPONDER_STATS_EN
    ,
    output logic [31:0]             rd_count_out,
    output logic [31:0]             wr_count_out
`endif
);

    localparam int c_ADDR_W = $clog2(MEM_WORDS);
    localparam logic [c_WAIT_CNT_W-1:0] c_WAIT_LOAD =
        (WAIT_STATES == 0) ? '0 : c_WAIT_CNT_W'(WAIT_STATES - 1);

    state_t                  r_state;
    logic [c_WAIT_CNT_W-1:0] r_wait_cnt;

    logic                    w_accept;
    logic                    w_in_range;
    logic                    w_is_write;
    logic [c_ADDR_W-1:0]     w_idx;
    logic [3:0]              w_we;
    logic                    w_rd_en;
    logic                    w_rd_zero;

    // Accesses are never taken while reset is asserted.
    assign w_accept   = (r_state == ST_ACCEPT) && !stall_out && !reset;
    assign w_in_range = in_range(addr_in, BASE_ADDR, MEM_WORDS);
    assign w_is_write = |wb_in;
    assign w_idx      = c_ADDR_W'((addr_in - BASE_ADDR) >> 2);
    assign w_we       = (w_accept && w_in_range) ? wb_in : 4'b0000;
    assign w_rd_en    = w_accept && !w_is_write && w_in_range;
    assign w_rd_zero  = w_accept && !w_is_write && !w_in_range;

    core_mem_ram #(
        .MEM_WORDS (MEM_WORDS),
        .ADDR_W    (c_ADDR_W)
    ) u_ram (
        .clk       (clock),
        .rst       (reset),
        .i_idx     (w_idx),
        .i_we      (w_we),
        .i_wdata   (data_in),
        .i_rd_en   (w_rd_en),
        .i_rd_zero (w_rd_zero),
        .o_rdata   (data_out)
    );

    // Access FSM. The counter is loaded with N-1 so that N edges are spent in
    // WAIT, giving exactly N stalled cycles between two accept edges.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_ACCEPT;
            r_wait_cnt <= '0;
            stall_out  <= 1'b0;
            err_out    <= 1'b0;
        end else begin
            if (w_accept && !w_in_range) begin
                err_out <= 1'b1;
            end
            case (r_state)
                ST_ACCEPT: begin
                    if (w_accept && (WAIT_STATES != 0)) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= c_WAIT_LOAD;
                        stall_out  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (r_wait_cnt == '0) begin
                        r_state   <= ST_ACCEPT;
                        stall_out <= 1'b0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_ACCEPT;
                    stall_out <= 1'b0;
                end
            endcase
        end
    end

`ifdef CORE_MEM_RESPONDER_STATS_EN
    // Only in-range accesses are counted; both counters stick at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_count_out <= 32'h0;
            wr_count_out <= 32'h0;
        end else if (w_accept && w_in_range) begin
            if (w_is_write) begin
                if (wr_count_out != 32'hFFFF_FFFF) begin
                    wr_count_out <= wr_count_out + 32'd1;
                end
            end else begin
                if (rd_count_out != 32'hFFFF_FFFF) begin
                    rd_count_out <= rd_count_out + 32'd1;
                end
            end
        end
    end
`endif

endmodule
`default_nettype wire
